// File: rtl/game_status_ctrl_module.sv
// Screen-select FSM (START/PLAY/END) with a debounced start key and VSYNC-aligned commits.
// Requests are queued in a single pending slot and applied only on a frame tick.
module game_status_ctrl_module #(
    parameter int DEBOUNCE_CYCLES = 800000,
    parameter int END_HOLD_CYCLES = 80000000
) (
    input  logic       CLK_40M,
    input  logic       RST,
    input  logic       key_start_in,
    input  logic       hit_wall_sig,
    input  logic       hit_body_sig,
    input  logic       Flash_over_sig,
    input  logic       VSYNC_Sig_in,
    output logic [2:0] Game_status,
    output logic       game_reset_sig,
    output logic       play_enable
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (END_HOLD_CYCLES > 1) ? $clog2(END_HOLD_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_MAX = TW'(END_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_START = 3'b001,
        ST_PLAY  = 3'b010,
        ST_END   = 3'b100
    } state_t;

    state_t          state;
    state_t          pend_tgt;
    logic            pend_vld;
    logic [TW-1:0]   end_timer;
    logic            flash_done;

    logic            key_s1, key_s2, key_db, key_db_q;
    logic [DW-1:0]   deb_cnt;
    logic            start_req;

    logic            vs_s1, vs_s2, vs_d, frame_tick;
    logic            commit;

    // Key synchronizer and debouncer
    always_ff @(posedge CLK_40M or posedge RST) begin
        if (RST) begin
            key_s1   <= 1'b0;
            key_s2   <= 1'b0;
            key_db   <= 1'b0;
            key_db_q <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            key_s1   <= key_start_in;
            key_s2   <= key_s1;
            key_db_q <= key_db;
            if (key_s2 != key_db) begin
                if (deb_cnt == DEB_MAX) begin
                    key_db  <= key_s2;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    assign start_req = key_db & ~key_db_q;

    // VSYNC synchronizer; frame_tick is registered so a commit lands 3 edges after sampling
    always_ff @(posedge CLK_40M or posedge RST) begin
        if (RST) begin
            vs_s1      <= 1'b1;
            vs_s2      <= 1'b1;
            vs_d       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vs_s1      <= VSYNC_Sig_in;
            vs_s2      <= vs_s1;
            vs_d       <= vs_s2;
            frame_tick <= vs_d & ~vs_s2;
        end
    end

    assign commit      = frame_tick & pend_vld;
    assign Game_status = state;

    always_ff @(posedge CLK_40M or posedge RST) begin
        if (RST) begin
            state          <= ST_START;
            pend_vld       <= 1'b0;
            pend_tgt       <= ST_START;
            play_enable    <= 1'b0;
            game_reset_sig <= 1'b0;
            end_timer      <= '0;
            flash_done     <= 1'b0;
        end else begin
            game_reset_sig <= 1'b0;
            case (state)
                ST_START, ST_PLAY, ST_END: begin
                    if (commit) begin
                        state          <= pend_tgt;
                        pend_vld       <= 1'b0;
                        play_enable    <= (pend_tgt == ST_PLAY);
                        game_reset_sig <= (state == ST_END) && (pend_tgt == ST_START);
                    end else if (!pend_vld) begin
                        if (state == ST_START && start_req) begin
                            pend_vld <= 1'b1;
                            pend_tgt <= ST_PLAY;
                        end else if (state == ST_PLAY && (hit_wall_sig || hit_body_sig)) begin
                            pend_vld <= 1'b1;
                            pend_tgt <= ST_END;
                        end else if (state == ST_END && start_req &&
                                     end_timer == HOLD_MAX && flash_done) begin
                            pend_vld <= 1'b1;
                            pend_tgt <= ST_START;
                        end
                    end
                end
                default: begin
                    state       <= ST_START;
                    pend_vld    <= 1'b0;
                    play_enable <= 1'b0;
                end
            endcase

            // Hold timer and flash flag live only while END is settled
            if (state == ST_END && !commit) begin
                if (end_timer != HOLD_MAX)
                    end_timer <= end_timer + 1'b1;
                if (Flash_over_sig)
                    flash_done <= 1'b1;
            end else begin
                end_timer  <= '0;
                flash_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_game_status_ctrl_module.sv
// Directed bench for game_status_ctrl_module with short debounce and END hold.
module tb_game_status_ctrl_module;

    localparam int DEB  = 4;
    localparam int HOLD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       key;
    logic       hit_wall;
    logic       hit_body;
    logic       flash_over;
    logic       vsync;
    logic [2:0] gs;
    logic       grs;
    logic       pe;

    int n_checks     = 0;
    int n_fail       = 0;
    int reset_pulses = 0;

    game_status_ctrl_module #(
        .DEBOUNCE_CYCLES(DEB),
        .END_HOLD_CYCLES(HOLD)
    ) dut (
        .CLK_40M       (clk),
        .RST           (rst),
        .key_start_in  (key),
        .hit_wall_sig  (hit_wall),
        .hit_body_sig  (hit_body),
        .Flash_over_sig(flash_over),
        .VSYNC_Sig_in  (vsync),
        .Game_status   (gs),
        .game_reset_sig(grs),
        .play_enable   (pe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (grs === 1'b1) reset_pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press();
        key = 1'b1;
        tick(10);
        key = 1'b0;
        tick(10);
    endtask

    // Commit (if any) happens on the 4th edge after vsync is driven low
    task automatic frame();
        vsync = 1'b0;
        tick(4);
        vsync = 1'b1;
        tick(4);
    endtask

    initial begin
        rst = 1'b1; key = 1'b0; hit_wall = 1'b0; hit_body = 1'b0;
        flash_over = 1'b0; vsync = 1'b1;
        tick(3);
        check("rst_status", 32'(gs), 32'h1);
        check("rst_play_en", 32'(pe), 32'h0);
        check("rst_greset", 32'(grs), 32'h0);
        rst = 1'b0;
        tick(2);

        // Short key glitch must not start the game
        key = 1'b1;
        tick(3);
        key = 1'b0;
        tick(10);
        for (int i = 0; i < 5; i++) begin
            frame();
            check($sformatf("glitch_frame%0d", i), 32'(gs), 32'h1);
        end

        // Clean press, then exact commit latency
        key = 1'b1;
        tick(10);
        key = 1'b0;
        tick(5);
        vsync = 1'b0;
        tick(3);
        check("lat_edge3_before", 32'(gs), 32'h1);
        tick(1);
        check("lat_commit_play", 32'(gs), 32'h2);
        check("play_en_on", 32'(pe), 32'h1);
        check("no_greset_start_play", 32'(grs), 32'h0);
        vsync = 1'b1;
        tick(4);
        check("greset_count0", 32'(reset_pulses), 32'h0);

        // Body hit mid-frame; wall hit while END pending is ignored
        tick(2);
        hit_body = 1'b1;
        tick(1);
        hit_body = 1'b0;
        tick(3);
        check("end_pending_hold", 32'(gs), 32'h2);
        hit_wall = 1'b1;
        tick(1);
        hit_wall = 1'b0;
        vsync = 1'b0;
        tick(3);
        check("end_before_commit", 32'(gs), 32'h2);
        tick(1);
        check("end_commit", 32'(gs), 32'h4);
        check("play_en_off", 32'(pe), 32'h0);
        vsync = 1'b1;
        tick(4);
        hit_wall = 1'b1;
        tick(1);
        hit_wall = 1'b0;
        frame();
        check("end_ignores_hit", 32'(gs), 32'h4);
        check("greset_count_end", 32'(reset_pulses), 32'h0);

        // Timer saturated but no flash seen: restart refused
        tick(20);
        press();
        frame();
        check("end_no_flash", 32'(gs), 32'h4);

        // Flash seen and timer saturated: restart with one reset pulse
        flash_over = 1'b1;
        tick(1);
        flash_over = 1'b0;
        tick(2);
        press();
        vsync = 1'b0;
        tick(3);
        check("restart_before", 32'(gs), 32'h4);
        tick(1);
        check("restart_commit", 32'(gs), 32'h1);
        check("restart_greset_hi", 32'(grs), 32'h1);
        check("restart_play_en", 32'(pe), 32'h0);
        tick(1);
        check("restart_greset_lo", 32'(grs), 32'h0);
        vsync = 1'b1;
        tick(3);
        check("greset_count1", 32'(reset_pulses), 32'h1);

        // Reset while a PLAY request is pending discards it
        press();
        rst = 1'b1;
        tick(2);
        check("midreq_rst_status", 32'(gs), 32'h1);
        check("midreq_rst_play_en", 32'(pe), 32'h0);
        rst = 1'b0;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            frame();
            check($sformatf("after_rst_frame%0d", i), 32'(gs), 32'h1);
        end

        // start_req lands in the frame_tick cycle: commit waits a frame
        key = 1'b1;
        tick(3);
        vsync = 1'b0;
        tick(4);
        check("same_tick_no_commit", 32'(gs), 32'h1);
        tick(3);
        key = 1'b0;
        vsync = 1'b1;
        tick(10);
        frame();
        check("same_tick_next_frame", 32'(gs), 32'h2);
        check("same_tick_play_en", 32'(pe), 32'h1);

        // Second END visit: early press after flash is refused, later press restarts
        hit_wall = 1'b1;
        tick(1);
        hit_wall = 1'b0;
        frame();
        check("end2_commit", 32'(gs), 32'h4);
        flash_over = 1'b1;
        tick(1);
        flash_over = 1'b0;
        press();
        frame();
        check("end2_early_press", 32'(gs), 32'h4);
        press();
        frame();
        check("end2_restart", 32'(gs), 32'h1);
        check("greset_count2", 32'(reset_pulses), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
